expu_arbiter: RTL

Shares one pipelined exponential unit between `N_REQ` requesters. It arbitrates valid/ready requests onto the unit's `float_i` input and tracks each accepted operand's requester ID through a tag pipeline matched to the unit's latency. It returns each result to the originating requester and stalls the whole unit through its `enable_i` when that requester back-pressures. It sits between the accelerator's requester ports and the unit instance, and drives the unit's `enable_i`, `clear_i` and `float_i` exclusively.

---
 rtl/expu_arb_pkg.sv | 24 ++
 rtl/expu_arb_grant.sv | 43 ++++
 rtl/expu_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/expu_arb_pkg.sv
// rtl/expu_arb_pkg.sv - shared types and constants for the exponential-unit arbiter
//
// Holds the arbiter FSM state encoding, the tag carried alongside each operand
// through the unit, and the default operand width.
package expu_arb_pkg;

  localparam int FLOAT_W_DEFAULT = 16;

  // Tag id field is sized for up to 256 requesters; the arbiter uses the low bits.
  localparam int TAG_ID_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } expu_arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } expu_tag_t;

endpackage

// File: rtl/expu_arb_grant.sv
// rtl/expu_arb_grant.sv - combinational priority / round-robin requester selector
//
// Searches valid_i starting at pointer_i and wrapping, returning the first hit.
// With pointer_i tied to 0 this is a plain lowest-index-wins priority encoder.
// Ports:
//   valid_i     - per-requester request
//   pointer_i   - index where the search starts (0..N_REQ-1)
//   grant_o     - one-hot grant, zero when nothing is valid
//   grant_idx_o - binary index of the grant (0 when no grant)
//   grant_any_o - a grant was made
module expu_arb_grant #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  pointer_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             grant_any_o
);

  // One extra bit so pointer + offset cannot overflow before the modulo fold.
  logic [ID_W:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, pointer_i} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!grant_any_o && valid_i[cand[ID_W-1:0]]) begin
        grant_any_o              = 1'b1;
        grant_o[cand[ID_W-1:0]]  = 1'b1;
        grant_idx_o              = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/expu_arbiter.sv
// rtl/expu_arbiter.sv - shares one pipelined exponential unit between N_REQ requesters
//
// Arbitrates requester operands onto the unit input, carries each requester id
// through a tag pipe matched to the unit latency, and returns results to the
// owner. A back-pressuring owner freezes the unit and the tag pipe together.
// Build option: define EXPU_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) with no pointer register.
// Ports:
//   clk_i, rst_i                - clock, async active-high reset
//   clear_i                     - synchronous flush of all in-flight work
//   drain_i / drain_done_o      - drain request pulse / completion pulse
//   req_valid_i/req_ready_o     - per-requester operand handshake
//   req_float_i                 - operands, requester k in slice k
//   res_valid_o/res_ready_i     - per-requester result handshake
//   res_float_o                 - shared result bus
//   busy_o                      - work in flight or FSM not idle
//   expu_enable_o/expu_clear_o  - unit enable_i / clear_i
//   expu_float_o/expu_float_i   - unit float_i / float_o
module expu_arbiter
  import expu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FLOAT_W = FLOAT_W_DEFAULT,
  parameter int LATENCY = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     drain_i,
  output logic                     drain_done_o,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*FLOAT_W-1:0] req_float_i,
  output logic [N_REQ-1:0]         res_valid_o,
  input  logic [N_REQ-1:0]         res_ready_i,
  output logic [FLOAT_W-1:0]       res_float_o,
  output logic                     busy_o,
  output logic                     expu_enable_o,
  output logic                     expu_clear_o,
  output logic [FLOAT_W-1:0]       expu_float_o,
  input  logic [FLOAT_W-1:0]       expu_float_i
);

  localparam int ID_W = $clog2(N_REQ);

  expu_tag_t       tag_q [LATENCY];
  expu_tag_t       tag_d [LATENCY];
  expu_arb_state_e state_q, state_d;

  expu_tag_t        head;
  logic             stall;
  logic             any_valid;
  logic             accept_ok;
  logic             accept;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [ID_W-1:0]  arb_ptr;

`ifdef EXPU_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  assign arb_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign arb_ptr = '0;
`endif

  expu_arb_grant #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_grant (
    .valid_i     (req_valid_i),
    .pointer_i   (arb_ptr),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // Result side: the head tag owns the result bus; its owner's ready gates the unit.
  always_comb begin
    head        = tag_q[LATENCY-1];
    res_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      res_valid_o[k] = head.valid && (head.id == TAG_ID_W'(k));
    end
    stall         = |(res_valid_o & ~res_ready_i);
    expu_enable_o = ~stall;
    res_float_o   = expu_float_i;
    expu_clear_o  = clear_i;
    any_valid     = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_valid = any_valid | tag_q[i].valid;
    end
  end

  // Request side: accept only when the pipe can move and no flush is pending.
  always_comb begin
    accept_ok    = ((state_q == IDLE) || (state_q == BUSY)) && !stall && !clear_i;
    req_ready_o  = accept_ok ? grant : '0;
    accept       = accept_ok && grant_any;
    expu_float_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready_o[k]) begin
        expu_float_o = req_float_i[k*FLOAT_W +: FLOAT_W];
      end
    end
    busy_o       = any_valid || (state_q != IDLE);
    drain_done_o = (state_q == DONE);
  end

  // Tag pipe: shifts in lockstep with the unit; a bubble enters when nothing is accepted.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (clear_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_d[i].valid = 1'b0;
      end
    end else if (expu_enable_o) begin
      tag_d[0].valid = accept;
      tag_d[0].id    = accept ? TAG_ID_W'(grant_idx) : '0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (drain_i) begin
            state_d = DRAIN;
          end else if (accept) begin
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (drain_i) begin
            state_d = DRAIN;
          end else if (!any_valid && !accept) begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (!any_valid) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule
